// File: rtl/utils_pkg.sv
// Shared types and constants for the load/store unit and its memory-facing logic.
package utils_pkg;

    localparam int unsigned DATA_WIDTH = 64;

    // Memory-controller direction encoding on mem_enwr_o.
    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

    // Access width / sign codes understood by the memory controller; 3'b111 is unused.
    typedef enum logic [2:0] {
        WID_B  = 3'b000,
        WID_H  = 3'b001,
        WID_W  = 3'b010,
        WID_D  = 3'b011,
        WID_BU = 3'b100,
        WID_HU = 3'b101,
        WID_WU = 3'b110
    } mem_wid_e;

    typedef enum logic [1:0] {
        EXC_NONE        = 2'b00,
        EXC_LD_MISALIGN = 2'b01,
        EXC_ST_MISALIGN = 2'b10,
        EXC_ILLEGAL_WID = 2'b11
    } lsu_exc_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/mem_align_check.sv
// Width legality and natural-alignment check for one memory request.
module mem_align_check
    import utils_pkg::*;
(
    input  logic     we,
    input  logic [2:0] wid,
    input  logic [2:0] addr,
    output lsu_exc_e exc
);

    logic illegal;
    logic misaligned;

    // Classify the request; an illegal width outranks misalignment.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (wid)
            WID_B:  ;
            WID_BU: illegal = we;
            WID_H:  misaligned = addr[0];
            WID_HU: begin
                misaligned = addr[0];
                illegal    = we;
            end
            WID_W:  misaligned = |addr[1:0];
            WID_WU: begin
                misaligned = |addr[1:0];
                illegal    = we;
            end
            WID_D:  misaligned = |addr;
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            exc = EXC_ILLEGAL_WID;
        end else if (misaligned) begin
            exc = we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end else begin
            exc = EXC_NONE;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of the memory controller data port.
module load_store_unit
    import utils_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_wid_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [1:0]            resp_exc_o,
    output logic                  mem_en_o,
    output logic                  mem_enwr_o,
    output logic [2:0]            mem_wid_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e            state_q;
    lsu_state_e            state_d;
    lsu_exc_e              req_exc;
    lsu_exc_e              exc_q;
    logic                  we_q;
    logic [2:0]            wid_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    mem_align_check u_align (
        .we   (req_we_i),
        .wid  (req_wid_i),
        .addr (req_addr_i[2:0]),
        .exc  (req_exc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: faulting requests skip memory entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = (req_exc != EXC_NONE) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS:  state_d = we_q ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Request latch on accept, read-data capture one cycle after the read edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            wid_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            if (state_q == S_IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                wid_q   <= req_wid_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rdata_q <= '0;
                exc_q   <= req_exc;
            end
            if (state_q == S_CAPTURE) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Handshake and memory strobes decoded from state; direction parks at read.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        mem_en_o     = 1'b0;
        mem_enwr_o   = MEM_READ;
        case (state_q)
            S_IDLE:   req_ready_o = 1'b1;
            S_ACCESS: begin
                mem_en_o   = 1'b1;
                mem_enwr_o = we_q ? MEM_WRITE : MEM_READ;
            end
            S_RESP:   resp_valid_o = 1'b1;
            default:  ;
        endcase
    end

    assign mem_wid_o    = wid_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign resp_rdata_o = rdata_q;
    assign resp_exc_o   = exc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed memory and a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_wid = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic        mem_en;
    logic        mem_enwr;
    logic [2:0]  mem_wid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_wid_i    (req_wid),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_exc_o   (resp_exc),
        .mem_en_o     (mem_en),
        .mem_enwr_o   (mem_enwr),
        .mem_wid_o    (mem_wid),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Two byte stores: what the memory really holds, and what the model says it should hold.
    logic [7:0] phys [logic [63:0]];
    logic [7:0] shadow [logic [63:0]];

    function automatic logic [7:0] get_byte(bit sh, logic [63:0] a);
        if (sh) return shadow.exists(a) ? shadow[a] : (a[7:0] ^ 8'h5A);
        return phys.exists(a) ? phys[a] : (a[7:0] ^ 8'h5A);
    endfunction

    function automatic int size_of(logic [2:0] wid);
        return 1 << (wid % 4);
    endfunction

    function automatic logic [63:0] mem_read(bit sh, logic [63:0] a, logic [2:0] wid);
        logic [63:0] v = '0;
        int sz = size_of(wid);
        for (int k = 0; k < sz; k++) v = v | (64'(get_byte(sh, a + 64'(k))) << (8 * k));
        if (wid < 3 && v[8*sz-1]) v = v | ~((64'h1 << (8 * sz)) - 64'h1);
        return v;
    endfunction

    function automatic void mem_write(bit sh, logic [63:0] a, logic [2:0] wid, logic [63:0] d);
        for (int k = 0; k < size_of(wid); k++) begin
            if (sh) shadow[a + 64'(k)] = d[8*k +: 8];
            else    phys[a + 64'(k)]   = d[8*k +: 8];
        end
    endfunction

    function automatic void preload(logic [63:0] a, logic [63:0] d);
        mem_write(1'b0, a, 3'd3, d);
        mem_write(1'b1, a, 3'd3, d);
    endfunction

    function automatic logic [1:0] exp_exc(logic we, logic [2:0] wid, logic [63:0] a);
        if (wid == 3'd7 || (we && wid >= 3'd4)) return 2'b11;
        if (a % 64'(size_of(wid)) != 0) return we ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // Memory controller: registered read data, write at the enabled edge.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_enwr) mem_rdata <= mem_read(1'b0, mem_addr, mem_wid);
            else          mem_write(1'b0, mem_addr, mem_wid, mem_wdata);
        end
    end

    // Reference model: one request in flight, tracked by edges elapsed since acceptance.
    bit          m_pending = 0;
    int          m_cnt = 0;
    int          m_lat = 0;
    logic        m_we;
    logic [2:0]  m_wid;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_exc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 0;
        end else if (m_pending) begin
            if (m_cnt >= m_lat && resp_ready) begin
                m_pending = 0;
            end else begin
                if (m_cnt == 1 && m_lat >= 2) begin
                    if (m_we) mem_write(1'b1, m_addr, m_wid, m_wdata);
                    else      m_rdata = mem_read(1'b1, m_addr, m_wid);
                end
                if (m_cnt < m_lat) m_cnt++;
            end
        end else if (req_valid) begin
            m_we      = req_we;
            m_wid     = req_wid;
            m_addr    = req_addr;
            m_wdata   = req_wdata;
            m_exc     = exp_exc(req_we, req_wid, req_addr);
            m_lat     = (m_exc != 2'b00) ? 1 : (req_we ? 2 : 3);
            m_rdata   = '0;
            m_cnt     = 1;
            m_pending = 1;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_mem_en", mem_en, 0);
        end else begin
            chk("req_ready", req_ready, !m_pending);
            chk("resp_valid", resp_valid, m_pending && m_cnt >= m_lat);
            if (m_pending && m_cnt >= m_lat) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_exc", resp_exc, m_exc);
            end
            chk("mem_en", mem_en, m_pending && m_cnt == 1 && m_lat >= 2);
            if (m_pending && m_cnt == 1 && m_lat >= 2) begin
                chk("mem_enwr", mem_enwr, !m_we);
                chk("mem_wid", mem_wid, m_wid);
                chk("mem_addr", mem_addr, m_addr);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end else begin
                chk("mem_enwr_idle", mem_enwr, 1);
            end
        end
    end

    // Issue one request from an idle unit and observe it until the response appears.
    task automatic run_req(input logic we, input logic [2:0] wid, input logic [63:0] a,
                           input logic [63:0] wd, output int lat, output logic [63:0] rd,
                           output logic [1:0] exc, output int en_cnt, output logic en_enwr,
                           output logic [2:0] en_wid, output logic [63:0] en_addr);
        int n = 0;
        en_cnt = 0; en_enwr = 1'bx; en_wid = 'x; en_addr = 'x;
        req_we = we; req_wid = wid; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        do begin
            @(negedge clk);
            if (n == 0) req_valid = 1'b0;
            n++;
            if (mem_en) begin
                en_cnt++; en_enwr = mem_enwr; en_wid = mem_wid; en_addr = mem_addr;
            end
        end while (!resp_valid && n < 20);
        if (!resp_valid) chk("resp_timeout", 0, 1);
        lat = n; rd = resp_rdata; exc = resp_exc;
        @(negedge clk);
    endtask

    int          lat, en_cnt;
    logic [63:0] rd, en_addr;
    logic [1:0]  exc;
    logic        en_enwr;
    logic [2:0]  en_wid;

    logic        bb_we [3]    = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  bb_wid [3]   = '{3'd2, 3'd0, 3'd1};
    logic [63:0] bb_addr [3]  = '{64'h100, 64'h101, 64'h100};
    logic [63:0] bb_wdata [3] = '{64'h0, 64'hAB, 64'h0};
    logic [63:0] bb_rd [$];
    logic [1:0]  bb_exc [$];

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_mem_en", mem_en, 0);
        @(negedge clk);

        preload(64'h100, 64'h1122334455667788);
        run_req(1'b0, 3'd3, 64'h100, 64'h0, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("ld_d_lat", lat, 3);
        chk("ld_d_en_cnt", en_cnt, 1);
        chk("ld_d_enwr", en_enwr, 1);
        chk("ld_d_wid", en_wid, 3'b011);
        chk("ld_d_rdata", rd, 64'h1122334455667788);
        chk("ld_d_exc", exc, 2'b00);

        run_req(1'b1, 3'd2, 64'h204, 64'hDEADBEEF, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("st_w_lat", lat, 2);
        chk("st_w_en_cnt", en_cnt, 1);
        chk("st_w_enwr", en_enwr, 0);
        chk("st_w_wid", en_wid, 3'b010);
        chk("st_w_addr", en_addr, 64'h204);
        chk("st_w_rdata", rd, 0);
        chk("st_w_exc", exc, 2'b00);

        run_req(1'b0, 3'd1, 64'h101, 64'h0, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("ld_h_mis_lat", lat, 1); chk("ld_h_mis_en", en_cnt, 0); chk("ld_h_mis_exc", exc, 2'b01);
        run_req(1'b1, 3'd3, 64'h10C, 64'h55, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("st_d_mis_lat", lat, 1); chk("st_d_mis_en", en_cnt, 0); chk("st_d_mis_exc", exc, 2'b10);
        run_req(1'b0, 3'd7, 64'h0, 64'h0, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("ld_ill_lat", lat, 1); chk("ld_ill_en", en_cnt, 0); chk("ld_ill_exc", exc, 2'b11);
        run_req(1'b1, 3'd5, 64'h101, 64'h1, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("st_hu_lat", lat, 1); chk("st_hu_en", en_cnt, 0); chk("st_hu_exc", exc, 2'b11);
        chk("st_w_readback", mem_read(1'b0, 64'h204, 3'd6), 64'hDEADBEEF);

        // Back-pressure on a load response.
        preload(64'h108, 64'hCAFEF00D12345678);
        resp_ready = 1'b0;
        run_req(1'b0, 3'd3, 64'h108, 64'h0, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("bp_lat", lat, 3);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_rdata", resp_rdata, 64'hCAFEF00D12345678);
            chk("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_ready", req_ready, 1);
        chk("bp_after_valid", resp_valid, 0);

        // Reset while a store is in ACCESS.
        preload(64'h300, 64'h0807060504030201);
        req_we = 1'b1; req_wid = 3'd3; req_addr = 64'h300; req_wdata = 64'hFFEEDDCCBBAA9988;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_access_en", mem_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_access_en_drop", mem_en, 0);
        chk("rst_access_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_valid", resp_valid, 0);
        chk("rst_after_ready", req_ready, 1);
        run_req(1'b0, 3'd3, 64'h300, 64'h0, lat, rd, exc, en_cnt, en_enwr, en_wid, en_addr);
        chk("rst_old_data", rd, 64'h0807060504030201);

        // Back-to-back with req_valid held high.
        begin
            int idx = 0;
            bit will_acc = 0;
            req_we = bb_we[0]; req_wid = bb_wid[0]; req_addr = bb_addr[0]; req_wdata = bb_wdata[0];
            req_valid = 1'b1;
            will_acc = req_ready;
            for (int c = 0; c < 40 && bb_rd.size() < 3; c++) begin
                @(negedge clk);
                if (resp_valid) begin
                    bb_rd.push_back(resp_rdata);
                    bb_exc.push_back(resp_exc);
                end
                if (will_acc) begin
                    idx++;
                    if (idx < 3) begin
                        req_we = bb_we[idx]; req_wid = bb_wid[idx];
                        req_addr = bb_addr[idx]; req_wdata = bb_wdata[idx];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
                will_acc = req_ready && req_valid;
            end
            req_valid = 1'b0;
            chk("bb_count", bb_rd.size(), 3);
            if (bb_rd.size() == 3) begin
                chk("bb_ld_w", bb_rd[0], 64'h0000000055667788);
                chk("bb_st_b", bb_rd[1], 64'h0);
                chk("bb_ld_h", bb_rd[2], 64'hFFFFFFFFFFFFAB88);
                chk("bb_exc0", bb_exc[0], 0);
                chk("bb_exc1", bb_exc[1], 0);
                chk("bb_exc2", bb_exc[2], 0);
            end
        end
        @(negedge clk);

        // Random traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_we     = $urandom_range(0, 1);
            req_wid    = 3'($urandom_range(0, 7));
            req_addr   = 64'h100 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 1) != 0) req_addr = req_addr & ~64'h7;
            if ($urandom_range(0, 15) == 0) req_addr = {32'($urandom), 32'($urandom)} & ~64'h7;
            req_wdata  = {32'($urandom), 32'($urandom)};
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the data port of the unified memory controller (addr/enwr/En/data/wid in, registered data_o out). Accepts one memory request at a time over a valid/ready handshake and checks width and alignment. Legal requests go to memory with the one-cycle registered read latency absorbed internally. Every request gets a response with data or an exception code over a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, 64 (from utils_pkg): address and data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  unit can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_wid_i`  in  3  width/sign code: B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110; 111 is illegal.
- `req_addr_i`  in  DATA_WIDTH  byte address.
- `req_wdata_i`  in  DATA_WIDTH  store data, right-aligned.
- `resp_valid_o`  out  1  response present.
- `resp_ready_i`  in  1  consumer takes the response.
- `resp_rdata_o`  out  DATA_WIDTH  load result, already extended by memory; 0 for stores and exceptions.
- `resp_exc_o`  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 illegal width.
- `mem_en_o`  out  1  memory enable.
- `mem_enwr_o`  out  1  memory direction: 0 = write, 1 = read.
- `mem_wid_o`  out  3  width code to memory.
- `mem_addr_o`  out  DATA_WIDTH  address to memory.
- `mem_wdata_o`  out  DATA_WIDTH  write data to memory.
- `mem_rdata_i`  in  DATA_WIDTH  memory read data, valid the cycle after the enabled read edge.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, latch we/wid/addr/wdata.
  - If the latched request is illegal or misaligned, latch the exception code and go to RESP.
  - Otherwise go to ACCESS.
- Legality rules:
  - wid=111 → exc 11.
  - Alignment required: H/HU addr[0]=0; W/WU addr[1:0]=0; D addr[2:0]=0; B/BU always aligned.
  - Stores with BU/HU/WU → exc 11.
  - Exception priority: illegal width over misaligned.
- ACCESS:
  - Drive `mem_en_o`=1, `mem_enwr_o`=!we, and wid/addr/wdata from the latched registers.
  - Store → RESP.
  - Load → CAPTURE.
- CAPTURE: `mem_en_o`=0; register `mem_rdata_i` into the response data register → RESP.
- RESP:
  - `resp_valid_o`=1.
  - Data and exception registers stay stable until `resp_ready_i`.
  - On handshake → IDLE.
- `mem_*` outputs are decoded combinationally from state and the latched registers.
- Outside ACCESS: `mem_en_o`=0 and `mem_enwr_o`=1 (read), so memory never sees a spurious write.
- `req_ready_o` is high only in IDLE. No request is accepted in the same cycle as a response handshake.

## Timing
- Accept edge T0. Latency from T0 to the `resp_valid_o` cycle:
  - exception: 1 cycle.
  - store: 2 cycles (memory writes at edge T1).
  - load: 3 cycles (memory reads at edge T1, data captured at edge T2).
- `resp_ready_i` held low stalls in RESP indefinitely. Outputs remain stable and `mem_en_o` stays 0.
- Minimum throughput: one request per 3 cycles (store), 4 cycles (load), 2 cycles (exception).
- Reset (`rst_n` low, async):
  - State → IDLE.
  - All latched registers → 0.
  - `resp_valid_o`, `mem_en_o` → 0 immediately.
  - `req_ready_o` → 1 once reset deasserts.
- Reset in ACCESS before the edge: the write is dropped.
- Reset in CAPTURE/RESP: the response is discarded.
- Address wrap-around is not the unit's concern; the full address is passed through.

## Structure
- Add to utils_pkg:
  - `mem_wid_e` enum (the seven width codes).
  - `lsu_exc_e` (NONE, LD_MISALIGN, ST_MISALIGN, ILLEGAL_WID).
  - `lsu_state_e`.
  - Memory-controller direction constants MEM_WRITE=0, MEM_READ=1.
- One combinational sub-module: `mem_align_check` (inputs we, wid, addr[2:0]; output `lsu_exc_e`).
- The FSM and registers live in `load_store_unit`.

## Test plan
- Load D at 0x100 with mem_rdata=0x1122334455667788:
  - ACCESS cycle shows en=1, enwr=1, wid=011.
  - resp_valid at T0+3 with rdata=0x1122334455667788, exc=00.
- Store W at 0x204, wdata=0xDEADBEEF:
  - exactly one cycle with en=1, enwr=0, wid=010, addr=0x204.
  - resp_valid at T0+2 with rdata=0, exc=00.
- Misaligned cases produce no mem_en pulse and resp at T0+1:
  - load H at 0x101 → exc=01.
  - store D at 0x10C → exc=10.
  - load wid=111 at 0x0 → exc=11.
  - store wid=101 → exc=11.
- Back-pressure: load with resp_ready=0 for 5 cycles.
  - resp_valid and rdata stay stable, req_ready=0 throughout.
  - After handshake, req_ready=1 on the next cycle.
- Async reset asserted during ACCESS of a store:
  - mem_en_o drops the same cycle, no write occurs, no response is issued.
  - A load to the same address then returns the old data.
- Back-to-back: load, store, load with req_valid held high.
  - Each is accepted only in IDLE.
  - Responses arrive in order with the correct data and exc.
